leve1_core: RTL and testbench

LEVE1_CORE -- requirements
Module: leve1_core

---
 rtl/leve1_core_if.sv | 23 ++
 rtl/leve1_core.sv | 172 +++++++++++++++++
 tb/tb_leve1_core.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/leve1_core_if.sv
// Instruction-fetch bus between the core and its instruction memory:
// a read-address channel (arvalid/arready/araddr) and a read-data channel
// (rvalid/rready/rdata).
interface leve1_core_if #(
  parameter int XLEN = 32
);
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata
  );
endinterface

// File: rtl/leve1_core.sv
// leve1_core: unpipelined RV32I integer core. Each instruction walks
// FETCH_A (address handshake) -> FETCH_D (data handshake) -> EXEC (retire).
// Memory and system instructions retire as no-ops; there is no data port.
module leve1_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            PC_EN,
  output logic [XLEN-1:0] PC_CNT,
  leve1_core_if.master    rii
);
  typedef enum logic [1:0] {FETCH_A, FETCH_D, EXEC} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t                 state, state_nx;
  logic                   started;
  logic [XLEN-1:0]        pc, pc_next, pc_plus4, jalr_sum;
  logic [31:0]            ir;
  logic [XLEN-1:0]        regs [32];

  logic [6:0]             opc, funct7;
  logic [4:0]             rd, rs1, rs2, shamt;
  logic [2:0]             f3;
  logic signed [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic signed [XLEN-1:0] rs1_s, rs2_s, alu_b, alu_res;
  logic                   legal_imm, legal_reg, take, wb_en;
  logic [XLEN-1:0]        wb_data;

  assign opc    = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = XLEN'(signed'(ir[31:20]));
  assign imm_b = XLEN'(signed'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_u = XLEN'(signed'({ir[31:12], 12'b0}));
  assign imm_j = XLEN'(signed'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  // x0 is hardwired to zero on the read side as well as the write side
  assign rs1_s = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_s = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Only the RV32I funct7 encodings count as ALU ops; anything else is a no-op
  assign legal_reg = (funct7 == 7'b0) ||
                     (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign legal_imm = (f3 == 3'b001) ? (funct7 == 7'b0) :
                     (f3 == 3'b101) ? (funct7 == 7'b0 || funct7 == 7'b0100000) :
                     1'b1;

  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_sum = rs1_s + imm_i;
  assign rii.araddr = pc;
  assign PC_CNT     = pc;

  // FSM next state and bus/retire strobes
  always_comb begin
    state_nx    = state;
    rii.arvalid = 1'b0;
    rii.rready  = 1'b0;
    PC_EN       = 1'b0;
    case (state)
      FETCH_A: begin
        rii.arvalid = started;
        if (started && rii.arready) state_nx = FETCH_D;
      end
      FETCH_D: begin
        rii.rready = 1'b1;
        if (rii.rvalid) state_nx = EXEC;
      end
      EXEC: begin
        PC_EN    = 1'b1;
        state_nx = FETCH_A;
      end
      default: state_nx = FETCH_A;
    endcase
  end

  // ALU for OP and OP-IMM; shift amount is the low 5 bits of the operand
  always_comb begin
    alu_b   = (opc == OP_REG) ? rs2_s : imm_i;
    shamt   = alu_b[4:0];
    alu_res = '0;
    case (f3)
      3'b000:  alu_res = (opc == OP_REG && ir[30]) ? rs1_s - alu_b : rs1_s + alu_b;
      3'b001:  alu_res = rs1_s << shamt;
      3'b010:  alu_res = XLEN'(rs1_s < alu_b);
      3'b011:  alu_res = XLEN'($unsigned(rs1_s) < $unsigned(alu_b));
      3'b100:  alu_res = rs1_s ^ alu_b;
      3'b101:  alu_res = ir[30] ? rs1_s >>> shamt : $signed($unsigned(rs1_s) >> shamt);
      3'b110:  alu_res = rs1_s | alu_b;
      default: alu_res = rs1_s & alu_b;
    endcase
  end

  // Branch condition
  always_comb begin
    case (f3)
      3'b000:  take = (rs1_s == rs2_s);
      3'b001:  take = (rs1_s != rs2_s);
      3'b100:  take = (rs1_s < rs2_s);
      3'b101:  take = (rs1_s >= rs2_s);
      3'b110:  take = ($unsigned(rs1_s) < $unsigned(rs2_s));
      3'b111:  take = ($unsigned(rs1_s) >= $unsigned(rs2_s));
      default: take = 1'b0;
    endcase
  end

  // Write-back value and next pc; all pc arithmetic wraps at XLEN bits
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    pc_next = pc_plus4;
    case (opc)
      OP_LUI:    begin wb_en = 1'b1;      wb_data = imm_u;       end
      OP_AUIPC:  begin wb_en = 1'b1;      wb_data = pc + imm_u;  end
      OP_IMM:    begin wb_en = legal_imm; wb_data = alu_res;     end
      OP_REG:    begin wb_en = legal_reg; wb_data = alu_res;     end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_next = pc + imm_j;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_next = {jalr_sum[XLEN-1:1], 1'b0};
        end
      end
      OP_BRANCH: if (take) pc_next = pc + imm_b;
      default: ;
    endcase
  end

  // Control state: FSM, pc, and the flag that holds off ARVALID until the first edge after reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= FETCH_A;
      pc      <= RESET_PC;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (state == EXEC) pc <= pc_next;
    end
  end

  // Instruction register, captured on the read-data handshake
  always_ff @(posedge CLK) begin
    if (state == FETCH_D && rii.rvalid) ir <= rii.rdata;
  end

  // Register file: cleared by reset, written once per retire; rs1 is read combinationally before this edge
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == EXEC && wb_en && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_leve1_core.sv
// Bench for leve1_core: instruction-memory slave with configurable
// handshake delays, expected retire addresses queued by the stimulus and
// popped by a monitor on every PC_EN pulse.
module tb_leve1_core;
  localparam int          XLEN = 32;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b1;
  logic            PC_EN;
  logic [XLEN-1:0] PC_CNT;

  leve1_core_if #(.XLEN(XLEN)) rii ();

  leve1_core #(.XLEN(XLEN), .RESET_PC(BASE)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .PC_EN  (PC_EN),
    .PC_CNT (PC_CNT),
    .rii    (rii)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  int          ar_wait = 0;
  int          r_wait = 0;
  bit          chk_iv = 1'b1;
  logic [31:0] exp_q [$];
  logic [31:0] imem [logic [31:0]];
  logic        ar_hs_q = 1'b0;
  logic        r_hs_q = 1'b0;
  logic [31:0] hs_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] e_u(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [19:0] hi);
    return {hi, rd, op};
  endfunction

  task automatic put(input logic [31:0] off, input logic [31:0] w);
    imem[BASE + off] = w;
  endtask

  task automatic exp_pc(input logic [31:0] off);
    exp_q.push_back(BASE + off);
  endtask

  task automatic wait_empty(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL retire_timeout: %0d retires outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Handshake sampling at the active edge
  always @(posedge CLK) begin
    ar_hs_q <= rii.arvalid && rii.arready;
    r_hs_q  <= rii.rvalid && rii.rready;
    if (rii.arvalid && rii.arready) hs_addr <= rii.araddr;
  end

  // Instruction memory slave, driven on the falling edge
  initial begin : slave
    int          cnt;
    bit          pend;
    logic [31:0] paddr;
    cnt = 0; pend = 1'b0; paddr = '0;
    rii.arready = 1'b0;
    rii.rvalid  = 1'b0;
    rii.rdata   = NOP;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        rii.arready = 1'b0;
        rii.rvalid  = 1'b0;
        pend = 1'b0;
        cnt  = 0;
      end else begin
        if (rii.rvalid && r_hs_q) rii.rvalid = 1'b0;
        if (rii.arready && ar_hs_q) begin
          rii.arready = 1'b0;
          pend  = 1'b1;
          paddr = hs_addr;
          cnt   = 0;
        end
        if (!pend && rii.arvalid && !rii.arready) begin
          if (cnt >= ar_wait) begin rii.arready = 1'b1; cnt = 0; end
          else cnt++;
        end else if (pend && !rii.rvalid) begin
          if (cnt >= r_wait) begin
            rii.rvalid = 1'b1;
            rii.rdata  = imem.exists(paddr) ? imem[paddr] : NOP;
            pend = 1'b0;
            cnt  = 0;
          end else cnt++;
        end
      end
    end
  end

  // Monitor: fetch address, ARVALID hold, retire scoreboard and interval
  initial begin : monitor
    int cyc;
    int last;
    bit av_prev;
    cyc = 0; last = -1; av_prev = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RSTn) begin
        av_prev = 1'b0;
        last = -1;
      end else begin
        if (rii.arvalid && exp_q.size() > 0) chk("araddr", rii.araddr, exp_q[0]);
        if (av_prev && !ar_hs_q) chk("arvalid_held", rii.arvalid, 1);
        av_prev = rii.arvalid;
        if (PC_EN) begin
          chk("rready_in_exec", rii.rready, 0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire: PC_CNT=%h with no retire expected", PC_CNT);
          end else begin
            chk("pc_cnt", PC_CNT, exp_q.pop_front());
          end
          if (chk_iv && last >= 0) chk("retire_interval", cyc - last, 3);
          last = cyc;
        end
      end
    end
  end

  initial begin : stim
    int n;
    // program image
    put(32'h00, e_i(7'h13, 3'b000, 1, 0, 12'd5));        // ADDI x1,x0,5
    put(32'h04, e_r(7'h00, 3'b000, 2, 1, 1));            // ADD x2,x1,x1
    put(32'h08, NOP);
    put(32'h0C, e_b(3'b000, 2, 0, 13'd8));               // BEQ x2,x0,+8 (not taken)
    put(32'h10, e_i(7'h13, 3'b000, 3, 0, 12'd10));       // ADDI x3,x0,10
    put(32'h14, e_b(3'b000, 2, 3, 13'd8));               // BEQ x2,x3,+8 (taken)
    put(32'h1C, e_i(7'h13, 3'b000, 0, 0, 12'd7));        // ADDI x0,x0,7
    put(32'h20, e_r(7'h00, 3'b000, 3, 0, 0));            // ADD x3,x0,x0
    put(32'h24, e_b(3'b000, 3, 0, 13'd8));               // BEQ x3,x0,+8 (taken)
    put(32'h2C, e_i(7'h03, 3'b010, 4, 0, 12'd0));        // LW x4,0(x0)
    put(32'h30, {7'b0, 5'd1, 5'd0, 3'b010, 5'b0, 7'h23}); // SW x1,0(x0)
    put(32'h34, e_b(3'b001, 4, 0, 13'd8));               // BNE x4,x0,+8 (not taken)
    put(32'h38, e_j(1, 21'h100));                        // JAL x1,+0x100
    put(32'h138, e_i(7'h67, 3'b000, 0, 1, 12'd0));       // JALR x0,0(x1)
    put(32'h3C, e_u(7'h37, 5, 20'h12345));               // LUI x5
    put(32'h40, e_i(7'h13, 3'b000, 5, 5, 12'h678));      // ADDI x5,x5,0x678
    put(32'h44, e_i(7'h13, 3'b000, 6, 0, 12'hFF0));      // ADDI x6,x0,-16
    put(32'h48, e_i(7'h13, 3'b101, 7, 6, 12'h402));      // SRAI x7,x6,2
    put(32'h4C, e_i(7'h13, 3'b101, 8, 6, 12'h01C));      // SRLI x8,x6,28
    put(32'h50, e_i(7'h13, 3'b000, 9, 0, 12'hFFC));      // ADDI x9,x0,-4
    put(32'h54, e_b(3'b001, 7, 9, 13'h40));              // BNE x7,x9 (not taken)
    put(32'h58, e_i(7'h13, 3'b000, 9, 0, 12'd15));       // ADDI x9,x0,15
    put(32'h5C, e_b(3'b001, 8, 9, 13'h40));              // BNE x8,x9 (not taken)
    put(32'h60, e_r(7'h00, 3'b011, 10, 0, 6));           // SLTU x10,x0,x6
    put(32'h64, e_r(7'h00, 3'b010, 11, 6, 0));           // SLT x11,x6,x0
    put(32'h68, e_r(7'h00, 3'b100, 12, 10, 11));         // XOR x12,x10,x11
    put(32'h6C, e_b(3'b001, 12, 0, 13'h40));             // BNE x12,x0 (not taken)
    put(32'h70, e_b(3'b100, 6, 0, 13'd8));               // BLT x6,x0,+8 (taken)
    put(32'h78, e_b(3'b110, 6, 0, 13'd8));               // BLTU x6,x0 (not taken)
    put(32'h7C, e_b(3'b111, 6, 1, 13'd8));               // BGEU x6,x1,+8 (taken)
    put(32'h84, e_u(7'h17, 14, 20'h0));                  // AUIPC x14,0
    put(32'h88, e_i(7'h67, 3'b000, 0, 5, 12'h001));      // JALR x0,1(x5)
    imem[32'h1234_5678] = e_i(7'h67, 3'b000, 0, 14, 12'h010); // JALR x0,16(x14)
    put(32'h94, 32'h0000_0073);                          // ECALL
    put(32'h98, e_i(7'h67, 3'b000, 1, 1, 12'h064));      // JALR x1,0x64(x1)
    put(32'hA0, e_i(7'h67, 3'b000, 0, 1, 12'h008));      // JALR x0,8(x1)

    // reset values, applied asynchronously before any clock edge
    #2 RSTn = 1'b0;
    #1;
    chk("rst_arvalid", rii.arvalid, 0);
    chk("rst_rready", rii.rready, 0);
    chk("rst_pc_en", PC_EN, 0);
    chk("rst_pc_cnt", PC_CNT, BASE);

    foreach (imem[a]) begin end
    exp_pc(32'h00); exp_pc(32'h04); exp_pc(32'h08); exp_pc(32'h0C);
    exp_pc(32'h10); exp_pc(32'h14); exp_pc(32'h1C); exp_pc(32'h20);
    exp_pc(32'h24); exp_pc(32'h2C); exp_pc(32'h30); exp_pc(32'h34);
    exp_pc(32'h38); exp_pc(32'h138); exp_pc(32'h3C); exp_pc(32'h40);
    exp_pc(32'h44); exp_pc(32'h48); exp_pc(32'h4C); exp_pc(32'h50);
    exp_pc(32'h54); exp_pc(32'h58); exp_pc(32'h5C); exp_pc(32'h60);
    exp_pc(32'h64); exp_pc(32'h68); exp_pc(32'h6C); exp_pc(32'h70);
    exp_pc(32'h78); exp_pc(32'h7C); exp_pc(32'h84); exp_pc(32'h88);
    exp_q.push_back(32'h1234_5678);
    exp_pc(32'h94); exp_pc(32'h98); exp_pc(32'hA0);

    repeat (3) @(negedge CLK);
    #2 RSTn = 1'b1;
    #1 chk("arvalid_before_edge", rii.arvalid, 0);
    @(posedge CLK);
    #1;
    chk("arvalid_first_edge", rii.arvalid, 1);
    chk("araddr_first", rii.araddr, BASE);
    wait_empty(2000);

    // stalled handshakes: four cycles of ARREADY low, RVALID three cycles late
    chk_iv = 1'b0;
    ar_wait = 4;
    r_wait = 3;
    exp_pc(32'hA4); exp_pc(32'hA8); exp_pc(32'hAC); exp_pc(32'hB0);
    wait_empty(2000);

    // reset while waiting for read data
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(rii.rready && !rii.rvalid) && n < 200);
    chk("reached_fetch_d", rii.rready, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("async_arvalid", rii.arvalid, 0);
    chk("async_rready", rii.rready, 0);
    chk("async_pc_en", PC_EN, 0);
    chk("async_pc_cnt", PC_CNT, BASE);

    // restart: x7 and x2 were non-zero before reset, so these branch
    // outcomes only hold if the register file was cleared
    put(32'h00, e_b(3'b001, 7, 0, 13'h40));              // BNE x7,x0 (not taken)
    ar_wait = 0;
    r_wait = 1;
    exp_pc(32'h00); exp_pc(32'h04); exp_pc(32'h08); exp_pc(32'h0C);
    exp_pc(32'h14); exp_pc(32'h1C); exp_pc(32'h20);
    repeat (2) @(negedge CLK);
    #2 RSTn = 1'b1;
    @(posedge CLK);
    #1 chk("restart_araddr", rii.araddr, BASE);
    wait_empty(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
